// File: rtl/bls_cpa_pkg.sv
// Shared types and helpers for the redundant-to-binary carry-propagate adder.
package bls_cpa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } cpa_state_t;

    // Number of SEG_LEN-wide segments needed to cover bit_len bits.
    function automatic int cpa_num_segs(input int bit_len, input int seg_len);
        return (bit_len + seg_len - 1) / seg_len;
    endfunction

endpackage

// File: rtl/cpa_segment_adder.sv
// Purely combinational SEG_LEN-bit adder with carry in/out; one segment of the
// iterative carry-propagate resolution.
module cpa_segment_adder #(
    parameter int SEG_LEN = 4
) (
    input  logic [SEG_LEN-1:0] a,
    input  logic [SEG_LEN-1:0] b,
    input  logic               cin,
    output logic [SEG_LEN-1:0] sum,
    output logic               cout
);

    logic [SEG_LEN:0] full;

    assign full        = {1'b0, a} + {1'b0, b} + (SEG_LEN+1)'(cin);
    assign {cout, sum} = full;

endmodule

// File: rtl/redundant_to_binary_cpa.sv
// Resolves a redundant carry/sum pair (C, S) into a binary BIT_LEN+1-bit result.
// Default build ripples the carry through one SEG_LEN-bit segment per cycle.
// Define CPA_SINGLE_CYCLE_EN to resolve the whole sum in a single ADD cycle.
module redundant_to_binary_cpa
    import bls_cpa_pkg::*;
#(
    parameter int BIT_LEN = 16,
    parameter int SEG_LEN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BIT_LEN-1:0] C,
    input  logic [BIT_LEN-1:0] S,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BIT_LEN-1:0] sum,
    output logic               carry_out,
    output logic               busy
);

    localparam int NUM_SEGS = cpa_num_segs(BIT_LEN, SEG_LEN);
    localparam int PAD_W    = NUM_SEGS * SEG_LEN;

    cpa_state_t       state;
    logic [PAD_W-1:0] c_q;
    logic [PAD_W-1:0] s_q;
    // Bit PAD_W holds the final carry; bits above BIT_LEN are zero when padded.
    logic [PAD_W:0]   res_q;
    logic             accept;
    logic             add_last;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = res_q[BIT_LEN-1:0];
    // With padding, bit BIT_LEN of the padded sum is the true carry out.
    assign carry_out = res_q[BIT_LEN];

`ifdef CPA_SINGLE_CYCLE_EN

    assign add_last = 1'b1;

    // Whole-width resolution in the single ADD cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (state == ADD) begin
            res_q <= {1'b0, c_q} + {1'b0, s_q};
        end
    end

`else

    localparam int SEG_IDX_W = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;

    logic [SEG_IDX_W-1:0] seg_idx;
    logic                 carry_q;
    logic [SEG_LEN-1:0]   seg_sum;
    logic                 seg_cout;

    assign add_last = (seg_idx == SEG_IDX_W'(NUM_SEGS - 1));

    cpa_segment_adder #(
        .SEG_LEN (SEG_LEN)
    ) u_seg_adder (
        .a    (c_q[SEG_LEN*seg_idx +: SEG_LEN]),
        .b    (s_q[SEG_LEN*seg_idx +: SEG_LEN]),
        .cin  (carry_q),
        .sum  (seg_sum),
        .cout (seg_cout)
    );

    // Segment counter and inter-segment carry; both restart on every accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_idx <= '0;
            carry_q <= 1'b0;
        end else if (accept) begin
            seg_idx <= '0;
            carry_q <= 1'b0;
        end else if (state == ADD) begin
            seg_idx <= seg_idx + SEG_IDX_W'(1);
            carry_q <= seg_cout;
        end
    end

    // Write one resolved segment per ADD cycle; the top bit tracks the running carry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q <= '0;
        end else if (state == ADD) begin
            res_q[SEG_LEN*seg_idx +: SEG_LEN] <= seg_sum;
            res_q[PAD_W]                      <= seg_cout;
        end
    end

`endif

    // Operands are captured only on the accepting edge, zero-extended to PAD_W.
    always_ff @(posedge clk) begin
        if (accept) begin
            c_q <= PAD_W'(C);
            s_q <= PAD_W'(S);
        end
    end

    // IDLE -> ADD on accept, ADD -> DONE after the last segment, DONE drains on out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= ADD;
                ADD:     if (add_last) state <= DONE;
                DONE:    if (out_ready) state <= accept ? ADD : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    if (PAD_W > BIT_LEN) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^res_q[PAD_W:BIT_LEN+1];
    end

endmodule

// File: tb/tb_redundant_to_binary_cpa.sv
// Randomized self-checking bench for redundant_to_binary_cpa: a 16/4 instance
// and an 18/4 (padded) instance, checked against plain C+S arithmetic.
module tb_redundant_to_binary_cpa;

`ifdef CPA_SINGLE_CYCLE_EN
    localparam int LAT_A = 1;
    localparam int LAT_B = 1;
`else
    localparam int LAT_A = (16 + 3) / 4;
    localparam int LAT_B = (18 + 3) / 4;
`endif

    logic clk = 1'b0;
    logic rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_cout, a_busy;
    logic [15:0] a_c, a_s, a_sum;
    logic [16:0] a_exp;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cout, b_busy;
    logic [17:0] b_c, b_s, b_sum;
    logic [18:0] b_exp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    redundant_to_binary_cpa #(.BIT_LEN(16), .SEG_LEN(4)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .C         (a_c),
        .S         (a_s),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .sum       (a_sum),
        .carry_out (a_cout),
        .busy      (a_busy)
    );

    redundant_to_binary_cpa #(.BIT_LEN(18), .SEG_LEN(4)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .C         (b_c),
        .S         (b_s),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .sum       (b_sum),
        .carry_out (b_cout),
        .busy      (b_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Offer an operand (also consumes a pending DONE result) and wait for its result.
    task automatic start_a(input logic [15:0] c, input logic [15:0] s);
        int lat;
        a_exp = {1'b0, c} + {1'b0, s};
        @(negedge clk);
        a_c = c; a_s = s; a_in_valid = 1'b1; a_out_ready = 1'b1;
        #1 check_eq("a_in_ready_acc", 32'(a_in_ready), 1);
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        a_c = 16'($urandom); a_s = 16'($urandom);
        lat = 0;
        while (!a_out_valid && lat < 40) begin
            check_eq("a_busy_add", 32'(a_busy), 1);
            @(posedge clk); #1;
            lat++;
        end
        check_eq("a_latency", lat, LAT_A);
        check_eq("a_sum", 32'(a_sum), 32'(a_exp[15:0]));
        check_eq("a_carry_out", 32'(a_cout), 32'(a_exp[16]));
        check_eq("a_busy_done", 32'(a_busy), 1);
        check_eq("a_in_ready_done", 32'(a_in_ready), 0);
    endtask

    // Hold the result under backpressure, optionally consume it.
    task automatic finish_a(input int hold, input bit release_it);
        repeat (hold) begin
            @(posedge clk); #1;
            check_eq("a_hold_valid", 32'(a_out_valid), 1);
            check_eq("a_hold_result", 32'({a_cout, a_sum}), 32'(a_exp));
            check_eq("a_hold_in_ready", 32'(a_in_ready), 0);
        end
        if (release_it) begin
            @(negedge clk);
            a_out_ready = 1'b1;
            @(posedge clk); #1;
            a_out_ready = 1'b0;
            check_eq("a_release_valid", 32'(a_out_valid), 0);
            check_eq("a_release_in_ready", 32'(a_in_ready), 1);
            check_eq("a_release_busy", 32'(a_busy), 0);
        end
    endtask

    task automatic start_b(input logic [17:0] c, input logic [17:0] s);
        int lat;
        b_exp = {1'b0, c} + {1'b0, s};
        @(negedge clk);
        b_c = c; b_s = s; b_in_valid = 1'b1; b_out_ready = 1'b1;
        #1 check_eq("b_in_ready_acc", 32'(b_in_ready), 1);
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        b_c = 18'($urandom); b_s = 18'($urandom);
        lat = 0;
        while (!b_out_valid && lat < 40) begin
            check_eq("b_busy_add", 32'(b_busy), 1);
            @(posedge clk); #1;
            lat++;
        end
        check_eq("b_latency", lat, LAT_B);
        check_eq("b_sum", 32'(b_sum), 32'(b_exp[17:0]));
        check_eq("b_carry_out", 32'(b_cout), 32'(b_exp[18]));
    endtask

    task automatic finish_b(input int hold, input bit release_it);
        repeat (hold) begin
            @(posedge clk); #1;
            check_eq("b_hold_valid", 32'(b_out_valid), 1);
            check_eq("b_hold_result", 32'({b_cout, b_sum}), 32'(b_exp));
        end
        if (release_it) begin
            @(negedge clk);
            b_out_ready = 1'b1;
            @(posedge clk); #1;
            b_out_ready = 1'b0;
            check_eq("b_release_valid", 32'(b_out_valid), 0);
            check_eq("b_release_in_ready", 32'(b_in_ready), 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_c = '0; a_s = '0; a_exp = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_c = '0; b_s = '0; b_exp = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_out_valid", 32'(a_out_valid), 0);
        check_eq("rst_sum", 32'(a_sum), 0);
        check_eq("rst_carry_out", 32'(a_cout), 0);
        check_eq("rst_busy", 32'(a_busy), 0);
        check_eq("rst_in_ready", 32'(a_in_ready), 1);
        check_eq("rst_b_in_ready", 32'(b_in_ready), 1);

        // Full carry ripple through every segment.
        start_a(16'h0001, 16'hFFFF);
        finish_a(0, 1);
        // No inter-segment carries; busy through ADD and DONE.
        start_a(16'h1234, 16'h4321);
        finish_a(0, 1);
        // Backpressure, then a back-to-back accept on the draining edge.
        start_a(16'hAAAA, 16'h5556);
        finish_a(3, 0);
        start_a(16'h00FF, 16'h0001);
        finish_a(1, 1);

        // Padded width: carry_out comes from bit 18 of the padded sum.
        start_b(18'h3FFFF, 18'h00001);
        finish_b(0, 1);
        start_b(18'h20000, 18'h20000);
        finish_b(2, 1);

        // Reset mid-ADD aborts the operand without a result.
        @(negedge clk);
        a_c = 16'hFFFF; a_s = 16'h0001; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("abort_in_ready", 32'(a_in_ready), 1);
        check_eq("abort_busy", 32'(a_busy), 0);
        repeat (LAT_A + 3) begin
            @(posedge clk); #1;
            check_eq("abort_no_valid", 32'(a_out_valid), 0);
        end

        for (int i = 0; i < 15; i++) begin
            start_a(16'($urandom), 16'($urandom));
            finish_a(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
        finish_a(0, 1);

        for (int i = 0; i < 10; i++) begin
            start_b(18'($urandom), 18'($urandom));
            finish_b(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
        finish_b(0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
